// File: rtl/ws2812_tx.sv
// ws2812_tx: WS2812 NRZ serialiser with a valid/ready pixel input.
// A pixel is sent as 24 bits in GRB order, MSB first. Each bit is BIT_CYC
// clocks long and starts high for T0H_CYC or T1H_CYC clocks. A frame_end
// request queues a low latch gap of RESET_CYC clocks. The gap runs once the
// pixel in flight has finished, and it takes priority over the next pixel.
// Every output is registered. Each output is computed from the next-state
// values, so it lines up with the state it describes.
module ws2812_tx #(
  parameter int T0H_CYC   = 20,
  parameter int T1H_CYC   = 40,
  parameter int BIT_CYC   = 63,
  parameter int RESET_CYC = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic       frame_end,
  output logic       led_dout,
  output logic       busy,
  output logic       frame_done
);

  // A single counter times both the bit periods and the latch gap.
  localparam int MAX_CYC = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYC - 1);
  localparam logic [CW-1:0] T0H        = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H        = CW'(T1H_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [23:0]   shreg_reg, shreg_next;
  logic [4:0]    bit_idx_reg, bit_idx_next;
  logic [CW-1:0] cyc_reg, cyc_next;
  logic          latch_pend_reg, latch_pend_next;
  logic          led_next, ready_next, busy_next, done_next;
  logic [CW-1:0] thigh;

  // Next state, shift register and counters, then the outputs derived from them.
  always_comb begin
    state_next      = state_reg;
    shreg_next      = shreg_reg;
    bit_idx_next    = bit_idx_reg;
    cyc_next        = cyc_reg;
    // frame_end pulses that arrive while a latch is already pending merge into it.
    latch_pend_next = latch_pend_reg | frame_end;
    done_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (latch_pend_reg) begin
          // A pending latch wins over a waiting pixel.
          state_next      = LATCH;
          cyc_next        = '0;
          latch_pend_next = 1'b0;
        end else if (pix_valid && pix_ready) begin
          state_next   = SEND;
          shreg_next   = {g_in, r_in, b_in};
          bit_idx_next = 5'd23;
          cyc_next     = '0;
        end
      end
      SEND: begin
        if (cyc_reg == BIT_LAST) begin
          cyc_next   = '0;
          shreg_next = {shreg_reg[22:0], 1'b0};
          if (bit_idx_reg == 5'd0) begin
            state_next = IDLE;
          end else begin
            bit_idx_next = bit_idx_reg - 5'd1;
          end
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end
      LATCH: begin
        if (cyc_reg == RESET_LAST) begin
          state_next = IDLE;
          cyc_next   = '0;
          done_next  = 1'b1;
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cyc_next   = '0;
      end
    endcase

    // The high time depends on the bit that is current in the next cycle.
    thigh      = shreg_next[23] ? T1H : T0H;
    led_next   = (state_next == SEND) && (cyc_next < thigh);
    ready_next = (state_next == IDLE) && !latch_pend_next;
    busy_next  = (state_next != IDLE) || latch_pend_next;
  end

  // State and output registers. Reset forces led_dout low without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      bit_idx_reg    <= '0;
      cyc_reg        <= '0;
      latch_pend_reg <= 1'b0;
      led_dout       <= 1'b0;
      pix_ready      <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      bit_idx_reg    <= bit_idx_next;
      cyc_reg        <= cyc_next;
      latch_pend_reg <= latch_pend_next;
      led_dout       <= led_next;
      pix_ready      <= ready_next;
      busy           <= busy_next;
      frame_done     <= done_next;
    end
  end

endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: directed bench for ws2812_tx with short timing parameters.
// Pixels are checked by decoding the captured led_dout waveform.
module tb_ws2812_tx;

  localparam int T0H = 2;
  localparam int T1H = 4;
  localparam int BIT = 6;
  localparam int RST = 10;
  localparam int PIX = 24 * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] r_in = '0, g_in = '0, b_in = '0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic       frame_end = 1'b0;
  logic       led_dout;
  logic       busy;
  logic       frame_done;

  ws2812_tx #(.T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BIT), .RESET_CYC(RST)) dut (
    .clk(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_end(frame_end),
    .led_dout(led_dout), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [23:0] grb;
  } vec_t;

  vec_t vecs [5];
  int   n_cmp  = 0;
  int   n_miss = 0;

  logic led_tr  [0:511];
  logic rdy_tr  [0:511];
  logic busy_tr [0:511];
  logic fd_tr   [0:511];

  // Record one comparison. A mismatch prints one FAIL line.
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait, within a cycle budget, until pix_ready is seen at a falling edge.
  task automatic wait_ready(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (pix_ready) seen = 1'b1;
    end
    check({name, "_ready_timeout"}, int'(seen), 1);
  endtask

  // Sample n cycles at the falling edge. frame_end is pulsed for one cycle after sample fe_at.
  task automatic capture(input int n, input int fe_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      led_tr[i]  = led_dout;
      rdy_tr[i]  = pix_ready;
      busy_tr[i] = busy;
      fd_tr[i]   = frame_done;
      frame_end  = (i == fe_at);
    end
    frame_end = 1'b0;
  endtask

  // Decode 24 bit windows. Each window must be a 2- or 4-cycle high pulse followed by low.
  task automatic decode(input int start, output logic [23:0] val, output int bad);
    val = '0;
    bad = 0;
    for (int k = 0; k < 24; k++) begin
      int h;
      h = 0;
      for (int j = 0; j < BIT; j++) if (led_tr[start + k*BIT + j]) h++;
      for (int j = 0; j < BIT; j++)
        if (led_tr[start + k*BIT + j] != (j < h)) bad++;
      if (h == T1H) val[23-k] = 1'b1;
      else if (h != T0H) bad++;
    end
  endtask

  // Count samples in [lo, hi] whose value is 1.
  function automatic int ones(input logic tr [0:511], input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i <= hi; i++) if (tr[i]) c++;
    return c;
  endfunction

  // Offer a pixel and return one tick past the accepting clock edge.
  task automatic offer(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input string name);
    r_in = r; g_in = g; b_in = b;
    pix_valid = 1'b1;
    wait_ready(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] val;
    int bad;
    int bad_cyc;

    vecs[0] = '{r: 8'hFF, g: 8'h00, b: 8'h80, grb: 24'h00FF80};
    vecs[1] = '{r: 8'h00, g: 8'hFF, b: 8'h00, grb: 24'hFF0000};
    vecs[2] = '{r: 8'h12, g: 8'h34, b: 8'h56, grb: 24'h341256};
    vecs[3] = '{r: 8'hA5, g: 8'h5A, b: 8'h0F, grb: 24'h5AA50F};
    vecs[4] = '{r: 8'h00, g: 8'h00, b: 8'h01, grb: 24'h000001};

    // Reset state, then pix_ready rising one cycle after reset is released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_led", int'(led_dout), 0);
    check("rst_ready", int'(pix_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_ready_first_cycle", int'(pix_ready), 0);
    bad_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!pix_ready || busy || led_dout || frame_done) bad_cyc++;
    end
    check("idle_after_release", bad_cyc, 0);

    // Single pixels taken from the table.
    for (int v = 0; v < 5; v++) begin
      offer(vecs[v].r, vecs[v].g, vecs[v].b, $sformatf("vec%0d", v));
      pix_valid = 1'b0;
      capture(PIX + 1, -1);
      decode(0, val, bad);
      check($sformatf("vec%0d_grb", v), int'(val), int'(vecs[v].grb));
      check($sformatf("vec%0d_shape", v), bad, 0);
      check($sformatf("vec%0d_ready_low", v), ones(rdy_tr, 0, PIX - 1), 0);
      check($sformatf("vec%0d_busy", v), ones(busy_tr, 0, PIX - 1), PIX);
      check($sformatf("vec%0d_ready_back", v), int'(rdy_tr[PIX]), 1);
      check($sformatf("vec%0d_idle_low", v), int'(led_tr[PIX]), 0);
    end

    // Back-to-back pixels with pix_valid held: exactly one idle low cycle between them.
    offer(8'h01, 8'h80, 8'hFF, "b2b_a");
    r_in = 8'hC3; g_in = 8'h3C; b_in = 8'h00;
    capture(2*PIX + 2, -1);
    pix_valid = 1'b0;
    decode(0, val, bad);
    check("b2b_first_grb", int'(val), 24'h8001FF);
    check("b2b_first_shape", bad, 0);
    check("b2b_gap_low", int'(led_tr[PIX]), 0);
    check("b2b_gap_ready", int'(rdy_tr[PIX]), 1);
    check("b2b_restart_high", int'(led_tr[PIX + 1]), 1);
    decode(PIX + 1, val, bad);
    check("b2b_second_grb", int'(val), 24'h3CC300);
    check("b2b_second_shape", bad, 0);
    check("b2b_end_ready", int'(rdy_tr[2*PIX + 1]), 1);

    // frame_end mid-pixel: the pixel completes, then an idle cycle and a 10-cycle latch, then the next pixel.
    offer(8'h0F, 8'hF0, 8'hAA, "latch_a");
    r_in = 8'h55; g_in = 8'h66; b_in = 8'h77;
    capture(2*PIX + RST + 3, 50);
    pix_valid = 1'b0;
    decode(0, val, bad);
    check("latch_first_grb", int'(val), 24'hF00FAA);
    check("latch_first_shape", bad, 0);
    check("latch_gap_low", ones(led_tr, PIX, PIX + RST + 1), 0);
    check("latch_ready_held_low", ones(rdy_tr, PIX, PIX + RST), 0);
    check("latch_busy_in_gap", ones(busy_tr, PIX, PIX + RST), RST + 1);
    check("latch_done_pos", int'(fd_tr[PIX + RST + 1]), 1);
    check("latch_done_count", ones(fd_tr, 0, 2*PIX + RST + 2), 1);
    check("latch_ready_after", int'(rdy_tr[PIX + RST + 1]), 1);
    decode(PIX + RST + 2, val, bad);
    check("latch_second_grb", int'(val), 24'h665577);
    check("latch_second_shape", bad, 0);

    // Reset during bit 10 of a pixel abandons it and drives led_dout low at once.
    offer(8'hFF, 8'hFF, 8'hFF, "rst_mid");
    pix_valid = 1'b0;
    capture(10*BIT + 2, -1);
    check("rst_mid_led_high_before", int'(led_tr[10*BIT + 1]), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_led_async", int'(led_dout), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ready", int'(pix_ready), 0);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_rel_ready_first", int'(pix_ready), 0);
    @(negedge clk);
    check("rst_mid_rel_ready", int'(pix_ready), 1);
    offer(8'h00, 8'h00, 8'h00, "rst_zero");
    pix_valid = 1'b0;
    capture(PIX + 1, -1);
    decode(0, val, bad);
    check("rst_zero_grb", int'(val), 0);
    check("rst_zero_shape", bad, 0);
    check("rst_zero_highs", ones(led_tr, 0, PIX - 1), 24 * T0H);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
